// File: rtl/uart_receptor_if.sv
// uart_receptor_if: serial line, consumer acknowledge and received-byte status of the UART receiver.
//   master: drives rx and rd, observes the byte and status (line driver / consumer side)
//   slave : the receiver itself
interface uart_receptor_if;
    logic       rx;
    logic       rd;
    logic [7:0] dout;
    logic       done;
    logic       data_ready;
    logic       busy;
    logic       frame_err;
    logic       overrun;
    modport master (output rx, rd, input dout, done, data_ready, busy, frame_err, overrun);
    modport slave (input rx, rd, output dout, done, data_ready, busy, frame_err, overrun);
endinterface

// File: rtl/uart_receptor.sv
// uart_receptor: oversampling 8N1 UART receiver with start/stop validation and sticky status.
//   clk_in         system clock, all logic on its rising edge
//   reset          asynchronous active-low reset
//   bus.rx         serial line (idles high, asynchronous)
//   bus.rd         consumer acknowledge, clears data_ready and overrun
//   bus.dout       last good byte, held
//   bus.done       one-cycle pulse per good byte
//   bus.data_ready set on good byte, cleared by rd
//   bus.busy       receiver not idle
//   bus.frame_err  stop bit of the last completed frame was low
//   bus.overrun    an unread byte was overwritten
module uart_receptor #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input logic          clk_in,
    input logic          reset,
    uart_receptor_if.slave bus
);
    localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DW  = $clog2(DIV);
    localparam int SW  = $clog2(OVERSAMPLE);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
    state_t state, state_nx;
    logic [DW-1:0] div_cnt;
    logic [SW-1:0] sample_cnt;
    logic [2:0]    bitpos;
    logic [7:0]    shift, dout;
    logic          rx_m, rx_s;
    logic          tick, half_hit, bit_hit;
    logic          good, bad, sample;
    logic          done, data_ready, frame_err, overrun;
    assign tick     = div_cnt == DW'(DIV - 1);
    // START counts from T0, so mid start bit is reached when the count shows OVERSAMPLE/2-1
    assign half_hit = sample_cnt == SW'(OVERSAMPLE / 2 - 1);
    assign bit_hit  = sample_cnt == SW'(OVERSAMPLE - 1);
    always_ff @(posedge clk_in or negedge reset)
        if (!reset)
            state <= IDLE;
        else
            state <= state_nx;
    always_comb begin
        state_nx = state;
        if (tick)
            case (state)
                IDLE:    state_nx = rx_s ? IDLE : START;
                START:   state_nx = half_hit ? (rx_s ? IDLE : DATA) : START;
                DATA:    state_nx = (bit_hit && bitpos == 3'd7) ? STOP : DATA;
                STOP:    state_nx = bit_hit ? (rx_s ? IDLE : BREAK) : STOP;
                BREAK:   state_nx = rx_s ? IDLE : BREAK;
                default: state_nx = IDLE;
            endcase
    end
    always_comb begin
        sample = tick && state == DATA && bit_hit;
        good   = tick && state == STOP && bit_hit && rx_s;
        bad    = tick && state == STOP && bit_hit && !rx_s;
    end
    always_ff @(posedge clk_in or negedge reset)
        if (!reset) begin
            div_cnt    <= '0;
            rx_m       <= 1'b1;
            rx_s       <= 1'b1;
            sample_cnt <= '0;
            bitpos     <= '0;
            shift      <= '0;
            dout       <= '0;
            done       <= 1'b0;
            data_ready <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            rx_m    <= bus.rx;
            rx_s    <= rx_m;
            // restart the tick count on every state change and at each bit boundary
            if (tick)
                sample_cnt <= (state_nx != state || bit_hit) ? '0 : sample_cnt + 1'b1;
            // bitpos wraps 7->0, so it is back at 0 whenever DATA is entered
            if (sample) begin
                shift[bitpos] <= rx_s;
                bitpos        <= bitpos + 1'b1;
            end
            if (good)
                dout <= shift;
            done       <= good;
            data_ready <= good | (data_ready & ~bus.rd);
            overrun    <= ~bus.rd & (overrun | (good & data_ready));
            frame_err  <= bad | (frame_err & ~good);
        end
    assign bus.dout       = dout;
    assign bus.done       = done;
    assign bus.data_ready = data_ready;
    assign bus.busy       = state != IDLE;
    assign bus.frame_err  = frame_err;
    assign bus.overrun    = overrun;
endmodule

// File: tb/tb_uart_receptor.sv
// tb_uart_receptor: directed checks of uart_receptor at DIV=10, 160 clk_in per bit.
module tb_uart_receptor;
    logic       clk_in = 1'b0;
    logic       reset = 1'b0;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_pass = 0;
    int         done_cnt = 0;
    int         wide = 0;
    int         d1 = 0;
    logic       done_q = 1'b0;
    logic       ok;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[8] = '{8'hA5, 8'h81, 8'h11, 8'h22, 8'h5A, 8'h00, 8'hFF, 8'h55};
    logic [9:0] f;

    uart_receptor_if bus();

    uart_receptor #(.CLK_HZ(1600000), .BAUD(10000), .OVERSAMPLE(16)) dut (
        .clk_in(clk_in),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc++;

    always @(negedge clk_in) begin
        if (bus.done) begin
            done_cnt++;
            got_q.push_back(bus.dout);
            if (done_q)
                wide++;
        end
        done_q = bus.done;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            bus.rx = fr[i];
            repeat (160) @(negedge clk_in);
        end
    endtask

    task automatic wait_done(output logic hit, input int lim);
        hit = 1'b0;
        for (int i = 0; i < lim && !hit; i++) begin
            @(negedge clk_in);
            hit = bus.done;
        end
    endtask

    task automatic pulse_rd;
        bus.rd = 1'b1;
        @(negedge clk_in);
        bus.rd = 1'b0;
    endtask

    initial begin
        bus.rx = 1'b1;
        bus.rd = 1'b0;
        repeat (3) @(negedge clk_in);
        check("rst_dout", bus.dout, 8'h00);
        check("rst_done", bus.done, 0);
        check("rst_ready", bus.data_ready, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_ferr", bus.frame_err, 0);
        check("rst_ovr", bus.overrun, 0);
        reset = 1'b1;
        repeat (20) @(negedge clk_in);

        send(8'hA5, 1'b1);
        check("a5_dout", bus.dout, 8'hA5);
        check("a5_ready", bus.data_ready, 1);
        check("a5_ferr", bus.frame_err, 0);
        check("a5_busy", bus.busy, 0);
        check("a5_count", done_cnt, 1);
        repeat (320) @(negedge clk_in);

        bus.rx = 1'b0;
        repeat (20) @(negedge clk_in);
        check("glitch_busy", bus.busy, 1);
        repeat (10) @(negedge clk_in);
        bus.rx = 1'b1;
        repeat (200) @(negedge clk_in);
        check("glitch_idle", bus.busy, 0);
        check("glitch_count", done_cnt, 1);
        check("glitch_dout", bus.dout, 8'hA5);
        check("glitch_ready", bus.data_ready, 1);

        send(8'h3C, 1'b0);
        bus.rx = 1'b0;
        repeat (20 * 160) @(negedge clk_in);
        check("brk_ferr", bus.frame_err, 1);
        check("brk_busy", bus.busy, 1);
        check("brk_count", done_cnt, 1);
        check("brk_dout", bus.dout, 8'hA5);
        bus.rx = 1'b1;
        repeat (40) @(negedge clk_in);
        check("brk_idle", bus.busy, 0);
        pulse_rd();
        check("brk_rd_ready", bus.data_ready, 0);
        check("brk_rd_ferr", bus.frame_err, 1);
        repeat (300) @(negedge clk_in);
        send(8'h81, 1'b1);
        check("81_dout", bus.dout, 8'h81);
        check("81_ferr", bus.frame_err, 0);
        check("81_ready", bus.data_ready, 1);
        check("81_count", done_cnt, 2);

        pulse_rd();
        repeat (200) @(negedge clk_in);
        send(8'h11, 1'b1);
        check("11_ready", bus.data_ready, 1);
        check("11_ovr", bus.overrun, 0);
        send(8'h22, 1'b1);
        check("22_ovr", bus.overrun, 1);
        check("22_dout", bus.dout, 8'h22);
        pulse_rd();
        check("rd_ready", bus.data_ready, 0);
        check("rd_ovr", bus.overrun, 0);
        repeat (200) @(negedge clk_in);

        f = {1'b1, 8'h77, 1'b0};
        for (int i = 0; i < 5; i++) begin
            bus.rx = f[i];
            repeat (160) @(negedge clk_in);
        end
        bus.rx = f[5];
        repeat (80) @(negedge clk_in);
        check("mid_busy", bus.busy, 1);
        reset = 1'b0;
        #1;
        check("ares_dout", bus.dout, 8'h00);
        check("ares_done", bus.done, 0);
        check("ares_ready", bus.data_ready, 0);
        check("ares_busy", bus.busy, 0);
        check("ares_ferr", bus.frame_err, 0);
        check("ares_ovr", bus.overrun, 0);
        bus.rx = 1'b1;
        repeat (5) @(negedge clk_in);
        reset = 1'b1;
        repeat (320) @(negedge clk_in);
        send(8'h5A, 1'b1);
        check("5a_dout", bus.dout, 8'h5A);
        check("5a_count", done_cnt, 5);
        check("5a_ferr", bus.frame_err, 0);
        check("5a_ready", bus.data_ready, 1);

        pulse_rd();
        repeat (320) @(negedge clk_in);
        fork
            begin
                send(8'h00, 1'b1);
                send(8'hFF, 1'b1);
                send(8'h55, 1'b1);
            end
            begin
                wait_done(ok, 2000);
                check("b2b_first_done", ok, 1);
                d1 = cyc;
                pulse_rd();
                // frames are 1600 clk_in apart, a multiple of the tick period, so
                // the third completion lands exactly 3200 cycles after the first
                repeat (3198) @(negedge clk_in);
                bus.rd = 1'b1;
                @(negedge clk_in);
                bus.rd = 1'b0;
                check("same_done", bus.done, 1);
                check("same_ready", bus.data_ready, 1);
                check("same_ovr", bus.overrun, 0);
                pulse_rd();
            end
        join
        repeat (50) @(negedge clk_in);
        check("b2b_ovr", bus.overrun, 0);
        check("b2b_ready", bus.data_ready, 0);
        check("total_done", done_cnt, 8);
        check("pulse_width", wide, 0);
        check("byte_count", got_q.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < got_q.size())
                check($sformatf("byte%0d", i), got_q[i], exp_q[i]);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
